fifo_rr_arbiter: RTL and testbench

- Round-robin read scheduler that shares one downstream FIFO among N_REQ upstream FIFOs.
- Each upstream FIFO is a standard FIFO instance with pop-on-read and a registered data_out (data valid the cycle after the pop).
- The block drives the one-hot fifo_rd vector, serves bursts of up to BURST_LEN words per grant, and honours downstream almost-full back-pressure.
- Popped words are forwarded as out_wr/out_data to the downstream FIFO write port.

---
 rtl/fifo_rr_arbiter.sv | 149 ++++++++++++++
 tb/tb_fifo_rr_arbiter.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rr_arbiter.sv
// Round-robin burst read scheduler: drains N_REQ upstream FIFOs into one downstream FIFO.
// Optional macro ARB_PRIO0_EN: requester 0 wins every arbitration while it is non-empty.
module fifo_rr_arbiter #(
  parameter int N_REQ     = 4,
  parameter int WORD_SIZE = 6,
  parameter int BURST_LEN = 4,
  parameter int IDX_L     = 2,
  parameter int CNT_L     = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_REQ-1:0]           fifo_empty,
  input  logic [N_REQ*WORD_SIZE-1:0] fifo_data,
  input  logic                       out_almost_full,
  output logic [N_REQ-1:0]           fifo_rd,
  output logic                       out_wr,
  output logic [WORD_SIZE-1:0]       out_data,
  output logic [N_REQ-1:0]           grant,
  output logic                       idle
);

  typedef enum logic [1:0] {IDLE, SERVE, PAUSE} state_t;

  state_t               state_q, state_d;
  logic [N_REQ-1:0]     grant_q, grant_d;
  logic [IDX_L-1:0]     owner_q, owner_d;
  logic [IDX_L-1:0]     rr_ptr_q, rr_ptr_d;
  logic [IDX_L-1:0]     pop_idx_q, pop_idx_d;
  logic [CNT_L-1:0]     burst_cnt_q, burst_cnt_d;
  logic                 out_wr_q, out_wr_d;
  logic [WORD_SIZE-1:0] hold_q, hold_d;

  logic [WORD_SIZE-1:0] word [N_REQ];
  logic [N_REQ-1:0]     rd;
  logic [IDX_L:0]       cand;
  logic                 win_found;
  logic [IDX_L-1:0]     win_idx;
  logic                 ptr_upd;

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_slice
      assign word[gi] = fifo_data[gi*WORD_SIZE +: WORD_SIZE];
    end
  endgenerate

  // Scan rr_ptr+1 .. rr_ptr+N_REQ; the current pointer holder is therefore considered last.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = {1'b0, rr_ptr_q} + (IDX_L+1)'(k);
      if (cand >= (IDX_L+1)'(N_REQ)) cand = cand - (IDX_L+1)'(N_REQ);
      if (!win_found && !fifo_empty[cand[IDX_L-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[IDX_L-1:0];
      end
    end
`ifdef ARB_PRIO0_EN
    if (!fifo_empty[0]) begin
      win_found = 1'b1;
      win_idx   = '0;
    end
    ptr_upd = (win_idx != '0);
`else
    ptr_upd = 1'b1;
`endif
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    burst_cnt_d = burst_cnt_q;
    rd          = '0;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d     = SERVE;
          grant_d     = {{(N_REQ-1){1'b0}}, 1'b1} << win_idx;
          owner_d     = win_idx;
          burst_cnt_d = '0;
          if (ptr_upd) rr_ptr_d = win_idx;
        end
      end
      SERVE: begin
        if (!fifo_empty[owner_q] && !out_almost_full && burst_cnt_q < CNT_L'(BURST_LEN)) begin
          rd[owner_q] = 1'b1;
          burst_cnt_d = burst_cnt_q + CNT_L'(1);
        end
        if (fifo_empty[owner_q] || burst_cnt_q == CNT_L'(BURST_LEN)) begin
          burst_cnt_d = '0;
          if (win_found) begin
            state_d = SERVE;
            grant_d = {{(N_REQ-1){1'b0}}, 1'b1} << win_idx;
            owner_d = win_idx;
            if (ptr_upd) rr_ptr_d = win_idx;
          end else begin
            state_d = IDLE;
            grant_d = '0;
          end
        end else if (out_almost_full) begin
          state_d = PAUSE;
        end
      end
      PAUSE: begin
        if (!out_almost_full) state_d = SERVE;
      end
      default: state_d = IDLE;
    endcase
    if (reset) rd = '0;
  end

  // Upstream data_out is registered, so the popped word is valid one cycle after the strobe.
  assign out_wr_d  = |rd;
  assign pop_idx_d = (|rd) ? owner_q : pop_idx_q;
  assign out_data  = out_wr_q ? word[pop_idx_q] : hold_q;
  assign hold_d    = out_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      owner_q     <= '0;
      rr_ptr_q    <= IDX_L'(N_REQ - 1);
      pop_idx_q   <= '0;
      burst_cnt_q <= '0;
      out_wr_q    <= 1'b0;
      hold_q      <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      pop_idx_q   <= pop_idx_d;
      burst_cnt_q <= burst_cnt_d;
      out_wr_q    <= out_wr_d;
      hold_q      <= hold_d;
    end
  end

  assign fifo_rd = rd;
  assign out_wr  = out_wr_q;
  assign grant   = grant_q;
  assign idle    = (state_q == IDLE);

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// Self-checking bench for fifo_rr_arbiter: behavioural upstream FIFOs plus a downstream write scoreboard.
module tb_fifo_rr_arbiter;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [3:0]    fifo_empty;
  logic [23:0]   fifo_data;
  logic          out_almost_full = 1'b0;
  logic [3:0]    fifo_rd;
  logic          out_wr;
  logic [5:0]    out_data;
  logic [3:0]    grant;
  logic          idle;

  int checks = 0;
  int passed = 0;

  logic [5:0] mem [4][16];
  int         wp [4];
  int         rp [4];
  logic [5:0] dreg [4];
  logic [5:0] exp_q [$];

  fifo_rr_arbiter #(
    .N_REQ(4), .WORD_SIZE(6), .BURST_LEN(4), .IDX_L(2), .CNT_L(3)
  ) dut (
    .clk(clk),
    .reset(reset),
    .fifo_empty(fifo_empty),
    .fifo_data(fifo_data),
    .out_almost_full(out_almost_full),
    .fifo_rd(fifo_rd),
    .out_wr(out_wr),
    .out_data(out_data),
    .grant(grant),
    .idle(idle)
  );

  always #5 clk = ~clk;

  // Upstream FIFO models: pop-on-read with registered data_out.
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (fifo_rd[i]) begin
        dreg[i] <= mem[i][rp[i] % 16];
        rp[i]   <= rp[i] + 1;
      end
    end
  end

  always_comb begin
    fifo_empty = '0;
    fifo_data  = '0;
    for (int i = 0; i < 4; i++) begin
      fifo_empty[i]       = (wp[i] == rp[i]);
      fifo_data[i*6 +: 6] = dreg[i];
    end
  end

  function automatic logic [5:0] mk(int id, int s);
    return 6'((id << 4) | s);
  endfunction

  task automatic push(int id, logic [5:0] w, bit track);
    mem[id][wp[id] % 16] = w;
    wp[id] = wp[id] + 1;
    if (track) exp_q.push_back(w);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    out_almost_full = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) wp[i] = rp[i];
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk); #1;
      checks++;
      if ({idle, grant, fifo_rd, out_wr} !== 10'b1_0000_0000_0)
        $display("FAIL reset_idle cycle %0d: idle/grant/rd/wr=%b required 1000000000", c, {idle, grant, fifo_rd, out_wr});
      else passed++;
    end
    checks++;
    if (out_data !== 6'h00) $display("FAIL reset_out_data: got %h required 00", out_data);
    else passed++;
  endtask

  task automatic test_single_requester();
    logic [5:0] w;
    logic [3:0] rd_exp;
    @(negedge clk);
    push(1, 6'h0A, 1'b1);
    push(1, 6'h0B, 1'b1);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk); #1;
      if (out_wr) begin
        checks++;
        if (exp_q.size() == 0) $display("FAIL single_wr: unexpected write %h, required none", out_data);
        else begin
          w = exp_q.pop_front();
          if (out_data !== w) $display("FAIL single_wr: got %h required %h", out_data, w);
          else begin passed++; $display("[%0t] single wr %h", $time, out_data); end
        end
      end
      rd_exp = (c <= 2) ? 4'b0010 : 4'b0000;
      checks++;
      if (fifo_rd !== rd_exp) $display("FAIL single_rd cycle %0d: got %b required %b", c, fifo_rd, rd_exp);
      else passed++;
      if (c == 1) begin
        checks++;
        if (grant !== 4'b0010) $display("FAIL single_grant: got %b required 0010", grant);
        else passed++;
      end
      if (c == 4) begin
        checks++;
        if ({idle, grant} !== 5'b1_0000) $display("FAIL single_idle: idle/grant=%b required 10000", {idle, grant});
        else passed++;
      end
    end
    checks++;
    if (exp_q.size() != 0) $display("FAIL single_drain: %0d words unwritten, required 0", exp_q.size());
    else passed++;
  endtask

  task automatic test_round_robin_bursts();
    int exp_gnt [8];
    int exp_pops [8];
    int n_exp;
    int next_seq [4];
    int runs = 0;
    int run_pops = 0;
    logic [3:0] prev_g = '0;
    logic [3:0] eg;
    logic [5:0] w;
`ifdef ARB_PRIO0_EN
    exp_gnt  = '{0, 1, 2, 3, 1, 2, 3, 0};
    exp_pops = '{6, 4, 4, 4, 2, 2, 2, 0};
    n_exp = 7;
`else
    exp_gnt  = '{0, 1, 2, 3, 0, 1, 2, 3};
    exp_pops = '{4, 4, 4, 4, 2, 2, 2, 2};
    n_exp = 8;
`endif
    for (int i = 0; i < 4; i++) next_seq[i] = 0;
    @(negedge clk);
    for (int i = 0; i < 4; i++)
      for (int s = 0; s < 6; s++) push(i, mk(i, s), 1'b0);
    for (int k = 0; k < n_exp; k++)
      for (int p = 0; p < exp_pops[k]; p++) begin
        exp_q.push_back(mk(exp_gnt[k], next_seq[exp_gnt[k]]));
        next_seq[exp_gnt[k]]++;
      end
    for (int c = 0; c < 60; c++) begin
      @(negedge clk); #1;
      if (out_wr) begin
        checks++;
        if (exp_q.size() == 0) $display("FAIL rr_wr: unexpected write %h, required none", out_data);
        else begin
          w = exp_q.pop_front();
          if (out_data !== w) $display("FAIL rr_wr: got %h required %h", out_data, w);
          else begin passed++; $display("[%0t] rr wr %h", $time, out_data); end
        end
      end
      checks++;
      if (!$onehot0(fifo_rd)) $display("FAIL rr_onehot: fifo_rd=%b required one-hot or zero", fifo_rd);
      else passed++;
      if (grant !== prev_g) begin
        if (prev_g != 4'b0000) begin
          checks++;
          if (run_pops != exp_pops[runs-1])
            $display("FAIL rr_burst run %0d: got %0d pops required %0d", runs-1, run_pops, exp_pops[runs-1]);
          else passed++;
        end
        if (grant != 4'b0000) begin
          checks++;
          if (runs >= n_exp) $display("FAIL rr_grant: extra grant %b, required none", grant);
          else begin
            eg = 4'b0001 << exp_gnt[runs];
            if (grant !== eg) $display("FAIL rr_grant run %0d: got %b required %b", runs, grant, eg);
            else passed++;
          end
          runs++;
        end
        run_pops = 0;
        prev_g = grant;
      end
      if (fifo_rd != 4'b0000) run_pops++;
    end
    checks++;
    if (runs != n_exp || exp_q.size() != 0)
      $display("FAIL rr_total: runs=%0d unwritten=%0d required runs=%0d unwritten=0", runs, exp_q.size(), n_exp);
    else passed++;
  endtask

  task automatic test_backpressure();
    logic [5:0] w;
    logic [3:0] rd_exp;
    logic [3:0] g_exp;
    @(negedge clk);
    for (int s = 0; s < 6; s++) push(2, mk(2, s), 1'b1);
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      out_almost_full = (c >= 3 && c <= 7);
      #1;
      if (out_wr) begin
        checks++;
        if (exp_q.size() == 0) $display("FAIL bp_wr: unexpected write %h, required none", out_data);
        else begin
          w = exp_q.pop_front();
          if (out_data !== w) $display("FAIL bp_wr: got %h required %h", out_data, w);
          else begin passed++; $display("[%0t] bp wr %h", $time, out_data); end
        end
      end
      rd_exp = (c == 1 || c == 2 || c == 9 || c == 10 || c == 12 || c == 13) ? 4'b0100 : 4'b0000;
      g_exp  = (c <= 14) ? 4'b0100 : 4'b0000;
      checks++;
      if (fifo_rd !== rd_exp || grant !== g_exp)
        $display("FAIL bp_cycle %0d: rd=%b grant=%b required rd=%b grant=%b", c, fifo_rd, grant, rd_exp, g_exp);
      else passed++;
    end
    checks++;
    if (exp_q.size() != 0 || idle !== 1'b1)
      $display("FAIL bp_drain: unwritten=%0d idle=%b required 0 and 1", exp_q.size(), idle);
    else passed++;
  endtask

  task automatic test_prio_refill();
    int exp_gnt [4];
    int exp_pops [4];
    int runs = 0;
    int run_pops = 0;
    int next_seq [4];
    logic [3:0] prev_g = '0;
    logic [3:0] eg;
    logic [5:0] w;
`ifdef ARB_PRIO0_EN
    exp_gnt = '{1, 0, 2, 3};
`else
    exp_gnt = '{1, 2, 3, 0};
`endif
    exp_pops = '{4, 2, 2, 2};
    for (int i = 0; i < 4; i++) next_seq[i] = 0;
    for (int k = 0; k < 4; k++)
      for (int p = 0; p < exp_pops[k]; p++) begin
        exp_q.push_back(mk(exp_gnt[k], next_seq[exp_gnt[k]]));
        next_seq[exp_gnt[k]]++;
      end
    @(negedge clk);
    for (int s = 0; s < 4; s++) push(1, mk(1, s), 1'b0);
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (c == 1)
        for (int s = 0; s < 2; s++) begin
          push(0, mk(0, s), 1'b0);
          push(2, mk(2, s), 1'b0);
          push(3, mk(3, s), 1'b0);
        end
      #1;
      if (out_wr) begin
        checks++;
        if (exp_q.size() == 0) $display("FAIL prio_wr: unexpected write %h, required none", out_data);
        else begin
          w = exp_q.pop_front();
          if (out_data !== w) $display("FAIL prio_wr: got %h required %h", out_data, w);
          else begin passed++; $display("[%0t] prio wr %h", $time, out_data); end
        end
      end
      if (grant !== prev_g) begin
        if (prev_g != 4'b0000) begin
          checks++;
          if (run_pops != exp_pops[runs-1])
            $display("FAIL prio_burst run %0d: got %0d pops required %0d", runs-1, run_pops, exp_pops[runs-1]);
          else passed++;
        end
        if (grant != 4'b0000) begin
          checks++;
          if (runs >= 4) $display("FAIL prio_grant: extra grant %b, required none", grant);
          else begin
            eg = 4'b0001 << exp_gnt[runs];
            if (grant !== eg) $display("FAIL prio_grant run %0d: got %b required %b", runs, grant, eg);
            else passed++;
          end
          runs++;
        end
        run_pops = 0;
        prev_g = grant;
      end
      if (fifo_rd != 4'b0000) run_pops++;
    end
    checks++;
    if (runs != 4 || exp_q.size() != 0)
      $display("FAIL prio_total: runs=%0d unwritten=%0d required runs=4 unwritten=0", runs, exp_q.size());
    else passed++;
  endtask

  task automatic test_reset_mid_burst();
    bit found = 1'b0;
    @(negedge clk);
    for (int s = 0; s < 4; s++) push(1, mk(1, s), 1'b0);
    for (int c = 0; c < 10 && !found; c++) begin
      @(negedge clk); #1;
      if (fifo_rd == 4'b0010 && out_wr) found = 1'b1;
    end
    checks++;
    if (!found) $display("FAIL mid_setup: got no pending write within 10 cycles, required one");
    else passed++;
    reset = 1'b1;
    for (int s = 0; s < 2; s++) begin
      push(0, mk(0, s), 1'b0);
      push(2, mk(2, s), 1'b0);
    end
    #1;
    checks++;
    if (fifo_rd !== 4'b0000) $display("FAIL mid_rd_in_reset: got %b required 0000", fifo_rd);
    else passed++;
    @(negedge clk); #1;
    checks++;
    if ({out_wr, grant, idle} !== 6'b0_0000_1)
      $display("FAIL mid_after_reset: wr/grant/idle=%b required 000001", {out_wr, grant, idle});
    else passed++;
    checks++;
    if (out_data !== 6'h00) $display("FAIL mid_out_data: got %h required 00", out_data);
    else passed++;
    reset = 1'b0;
    @(negedge clk); #1;
    checks++;
    if ({grant, idle} !== 5'b0001_0) $display("FAIL mid_first_grant: grant/idle=%b required 00010", {grant, idle});
    else passed++;
    do_reset();
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      wp[i] = 0;
      rp[i] = 0;
    end
    test_reset();
    test_single_requester();
    do_reset();
    test_round_robin_bursts();
    do_reset();
    test_backpressure();
    do_reset();
    test_prio_refill();
    do_reset();
    test_reset_mid_burst();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
